ddr3_dm_lane_tx_ctrl: RTL



---
 rtl/ddr3_dm_lane_tx_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ddr3_dm_lane_tx_ctrl.sv
// DDR3 DM lane fabric-side TX controller: write-mask latency/OE window and IOD delay-line sequencer.
// Optional macro DDR3_DM_TAPCNT_EN adds the signed TAP_POS tap-position counter output.
module ddr3_dm_lane_tx_ctrl #(
    parameter int unsigned MAX_WR_LAT = 7,
    parameter int unsigned MOVE_GAP   = 3,
    parameter int unsigned TAP_W      = 8
) (
    input  logic             FAB_CLK,
    input  logic             ARST_N,
    input  logic [2:0]       WR_LAT,
    input  logic             WRDATA_EN,
    input  logic [7:0]       WRDATA_MASK,
    output logic [7:0]       TX_DATA_0,
    output logic [3:0]       OE_DATA_0,
    input  logic             DLY_REQ,
    input  logic             DLY_LOAD,
    input  logic             DLY_DIR,
    input  logic [TAP_W-1:0] DLY_TAPS,
    output logic             DELAY_LINE_MOVE_0,
    output logic             DELAY_LINE_DIRECTION_0,
    output logic             DELAY_LINE_LOAD_0,
    input  logic             DELAY_LINE_OUT_OF_RANGE_0,
    output logic             DLY_BUSY,
    output logic             DLY_DONE,
    output logic             DLY_ERR
`ifdef DDR3_DM_TAPCNT_EN
    ,
    output logic signed [TAP_W:0] TAP_POS
`endif
);

    localparam int unsigned Depth = MAX_WR_LAT + 2;
    localparam int unsigned IdxW  = $clog2(Depth);
    localparam int unsigned GapW  = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;

    // ---------------------------------------------------------------- write path
    logic [Depth-1:0] en_q;
    logic [7:0]       mask_q [MAX_WR_LAT+1];
    logic [IdxW-1:0]  lat;
    logic             cur_en, pre_en, post_en;
    logic [7:0]       tx_d, tx_q;
    logic [3:0]       oe_d, oe_q;

    always_comb begin
        if (32'(WR_LAT) > MAX_WR_LAT) lat = IdxW'(MAX_WR_LAT);
        else                          lat = IdxW'(WR_LAT);
    end

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            en_q <= '0;
            for (int i = 0; i <= int'(MAX_WR_LAT); i++) mask_q[i] <= '0;
        end else begin
            en_q      <= {en_q[Depth-2:0], WRDATA_EN};
            mask_q[0] <= WRDATA_MASK;
            for (int i = 1; i <= int'(MAX_WR_LAT); i++) mask_q[i] <= mask_q[i-1];
        end
    end

    // Stage k is visible k+1 cycles after acceptance; the output register adds one more.
    always_comb begin
        cur_en  = en_q[lat];
        post_en = en_q[lat + IdxW'(1)];
        pre_en  = (lat == '0) ? WRDATA_EN : en_q[lat - IdxW'(1)];
        tx_d    = 8'h00;
        oe_d    = 4'h0;
        if (cur_en) begin
            tx_d = mask_q[lat];
            oe_d = 4'hF;
        end else begin
            oe_d[3] = pre_en;
            oe_d[0] = post_en;
        end
    end

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            tx_q <= '0;
            oe_q <= '0;
        end else begin
            tx_q <= tx_d;
            oe_q <= oe_d;
        end
    end

    assign TX_DATA_0 = tx_q;
    assign OE_DATA_0 = oe_q;

    // ------------------------------------------------------- delay sequencer
    typedef enum logic [2:0] {StIdle, StLoad, StSetDir, StMove, StGap, StDone} dly_state_e;

    dly_state_e       state_q, state_d;
    logic [TAP_W-1:0] taps_q, taps_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q <= StIdle;
            taps_q  <= '0;
            gap_q   <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            taps_q  <= taps_d;
            gap_q   <= gap_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        taps_d  = taps_q;
        gap_d   = gap_q;
        dir_d   = dir_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (DLY_REQ) begin
                    taps_d  = DLY_TAPS;
                    dir_d   = DLY_DIR;
                    err_d   = 1'b0;
                    state_d = DLY_LOAD ? StLoad : StSetDir;
                end
            end
            StLoad:   state_d = (taps_q != '0) ? StSetDir : StDone;
            StSetDir: state_d = (taps_q != '0) ? StMove : StDone;
            StMove: begin
                taps_d = taps_q - TAP_W'(1);
                if (DELAY_LINE_OUT_OF_RANGE_0) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else if (taps_q == TAP_W'(1)) begin
                    state_d = StDone;
                end else begin
                    gap_d   = GapW'(MOVE_GAP - 1);
                    state_d = StGap;
                end
            end
            StGap: begin
                if (DELAY_LINE_OUT_OF_RANGE_0) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else if (gap_q == '0) begin
                    state_d = StMove;
                end else begin
                    gap_d = gap_q - GapW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Pulses decode straight from the state register so reset kills them at once.
    assign DELAY_LINE_MOVE_0      = (state_q == StMove);
    assign DELAY_LINE_LOAD_0      = (state_q == StLoad);
    assign DELAY_LINE_DIRECTION_0 = dir_q;
    assign DLY_BUSY               = (state_q != StIdle);
    assign DLY_DONE               = (state_q == StDone);
    assign DLY_ERR                = err_q;

`ifdef DDR3_DM_TAPCNT_EN
    localparam logic signed [TAP_W:0] PosMax = {1'b0, {TAP_W{1'b1}}};
    localparam logic signed [TAP_W:0] PosMin = {1'b1, {TAP_W{1'b0}}};

    logic signed [TAP_W:0] pos_q;

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            pos_q <= '0;
        end else if (state_q == StLoad) begin
            pos_q <= '0;
        end else if (state_q == StMove) begin
            if (dir_q && (pos_q != PosMax))       pos_q <= pos_q + (TAP_W+1)'(1);
            else if (!dir_q && (pos_q != PosMin)) pos_q <= pos_q - (TAP_W+1)'(1);
        end
    end

    assign TAP_POS = pos_q;
`endif

endmodule
